// File: rtl/comanda_punte_h.sv
// H-bridge command block: synchronises per-side direction codes, inserts a dead-time coast on
// every code change and drives bridge pins plus a shared-counter PWM enable for each side.
module comanda_punte_h #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned PRESCALER   = 195,
  parameter int unsigned DEAD_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          directie_driver_a_i,
  input  logic [1:0]          directie_driver_b_i,
  input  logic [PWM_BITS-1:0] viteza_a_i,
  input  logic [PWM_BITS-1:0] viteza_b_i,
  output logic [1:0]          punte_a_o,
  output logic                en_a_o,
  output logic [1:0]          punte_b_o,
  output logic                en_b_o,
  output logic                pauza_a_o,
  output logic                pauza_b_o
);

  localparam int unsigned PrescW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam int unsigned DtW    = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [PrescW-1:0]   PrescLast = PrescW'(PRESCALER - 1);
  localparam logic [DtW-1:0]      DtLoad    = DtW'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] CntMax    = '1;

  typedef enum logic {StActiv, StPauza} state_e;

  // Shared PWM timebase
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic                tick, wrap;

  // Per-side state, index 0 = side A (right), 1 = side B (left)
  logic [1:0][1:0]          dir_in;
  logic [1:0][PWM_BITS-1:0] viteza_in;
  logic [1:0][1:0]          sync1_q, sync2_q;
  logic [1:0][PWM_BITS-1:0] duty_q, duty_d;
  logic [1:0][1:0]          cmd_q, cmd_d;
  logic [1:0][DtW-1:0]      dt_q, dt_d;
  state_e                   state_q [2];
  state_e                   state_d [2];
  logic [1:0][1:0]          punte_q, punte_d;
  logic [1:0]               en_q, en_d;
  logic [1:0]               pauza_q, pauza_d;
  logic [1:0]               pwm_on;

  assign dir_in    = {directie_driver_b_i, directie_driver_a_i};
  assign viteza_in = {viteza_b_i, viteza_a_i};

  assign tick    = (presc_q == PrescLast);
  assign wrap    = tick && (cnt_q == CntMax);
  assign presc_d = tick ? '0 : presc_q + PrescW'(1);
  assign cnt_d   = tick ? cnt_q + PWM_BITS'(1) : cnt_q;

  always_comb begin
    duty_d  = duty_q;
    cmd_d   = cmd_q;
    dt_d    = dt_q;
    state_d = state_q;
    punte_d = '0;
    en_d    = '0;
    pauza_d = '1;
    pwm_on  = '0;
    for (int i = 0; i < 2; i++) begin
      // Duty only moves at the period boundary so a period is never cut short.
      if (wrap) begin
        duty_d[i] = viteza_in[i];
      end

      unique case (state_q[i])
        StActiv: begin
          if (sync2_q[i] != cmd_q[i]) begin
            state_d[i] = StPauza;
            dt_d[i]    = DtLoad;
          end
        end
        StPauza: begin
          // sync2 is about to take a new value this edge: restart the pause.
          if (sync1_q[i] != sync2_q[i]) begin
            dt_d[i] = DtLoad;
          end else if (dt_q[i] == '0) begin
            cmd_d[i]   = sync2_q[i];
            state_d[i] = StActiv;
          end else begin
            dt_d[i] = dt_q[i] - DtW'(1);
          end
        end
        default: ;
      endcase

      // Outputs are registered from next-state values so they line up with the FSM.
      pwm_on[i] = (cnt_d < duty_d[i]);
      if (state_d[i] == StActiv) begin
        pauza_d[i] = 1'b0;
        punte_d[i] = cmd_d[i];
        unique case (cmd_d[i])
          2'b11:        en_d[i] = 1'b1;
          2'b10, 2'b01: en_d[i] = pwm_on[i];
          default:      en_d[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      duty_q  <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      cmd_q   <= '0;
      dt_q    <= {2{DtLoad}};
      punte_q <= '0;
      en_q    <= '0;
      pauza_q <= '1;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= StPauza;
      end
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      sync1_q <= dir_in;
      sync2_q <= sync1_q;
      cmd_q   <= cmd_d;
      dt_q    <= dt_d;
      punte_q <= punte_d;
      en_q    <= en_d;
      pauza_q <= pauza_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign punte_a_o = punte_q[0];
  assign punte_b_o = punte_q[1];
  assign en_a_o    = en_q[0];
  assign en_b_o    = en_q[1];
  assign pauza_a_o = pauza_q[0];
  assign pauza_b_o = pauza_q[1];

endmodule
